// File: rtl/encout_elc_in_event_queue_wr.sv
// Write side of the ELC-input event queue. Each rising edge of the activity
// clock is one event: the tag is stored and the Gray write pointer advances,
// unless the queue is full, in which case the event is dropped and counted.
`timescale 1ns/1ps

module encout_elc_in_event_queue_wr #(
   parameter int unsigned AW          = 3,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned DROP_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              w_elc_in_act_clk,
   input  logic              w_elc_in_act_resetn,
   input  logic [TAG_W-1:0]  i_elc_tag,
   input  logic [AW:0]       i_rd_ptr_gray,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [TAG_W-1:0]  o_rd_data,
   output logic [AW:0]       o_wr_ptr_gray,
   output logic              o_full,
   output logic              o_overflow,
   output logic [DROP_W-1:0] o_drop_cnt
);

   localparam int unsigned PW    = AW + 1;
   localparam int unsigned DEPTH = 2 ** AW;

   logic [PW-1:0]                   wr_bin;
   logic [PW-1:0]                   wr_gray;
   logic [PW-1:0]                   wr_bin_inc;
   logic [PW-1:0]                   wr_gray_inc;
   logic [SYNC_STAGES-1:0][PW-1:0]  rd_sync;
   logic [PW-1:0]                   rd_s;
   logic                            full;
   logic                            overflow;
   logic [DROP_W-1:0]               drop_cnt;
   logic [TAG_W-1:0]                mem [DEPTH];

   // Oldest synchroniser stage is the read pointer as this domain sees it
   assign rd_s = rd_sync[SYNC_STAGES-1];

   // Full when write pointer is exactly one lap ahead: top two Gray bits inverted
   assign full = (wr_gray == {~rd_s[AW:AW-1], rd_s[AW-2:0]});

   // Next write pointer in binary and Gray
   always_comb begin
      wr_bin_inc  = wr_bin + PW'(1);
      wr_gray_inc = wr_bin_inc ^ (wr_bin_inc >> 1);
   end

   // Read pointer synchroniser chain
   always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
      if (!w_elc_in_act_resetn) begin
         rd_sync <= '0;
      end else begin
         rd_sync[0] <= i_rd_ptr_gray;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            rd_sync[i] <= rd_sync[i-1];
         end
      end
   end

   // Write pointer advance, or drop accounting when full
   always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
      if (!w_elc_in_act_resetn) begin
         wr_bin   <= '0;
         wr_gray  <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (!full) begin
         wr_bin  <= wr_bin_inc;
         wr_gray <= wr_gray_inc;
      end else begin
         overflow <= 1'b1;
         if (drop_cnt != {DROP_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

   // Event tag storage; not reset, contents valid once written
   always_ff @(posedge w_elc_in_act_clk) begin
      if (!full) begin
         mem[wr_bin[AW-1:0]] <= i_elc_tag;
      end
   end

   // Consumer read is an unregistered mux of the array
   assign o_rd_data     = mem[i_rd_addr];
   assign o_wr_ptr_gray = wr_gray;
   assign o_full        = full;
   assign o_overflow    = overflow;
   assign o_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_encout_elc_in_event_queue_wr.sv
// Bench for the ELC-input event queue write side. Accepted writes are pushed
// to a scoreboard and checked later through the consumer read port.
`timescale 1ns/1ps

module tb_encout_elc_in_event_queue_wr;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       clk_run = 1'b0;
   logic [3:0] tag     = '0;
   logic [3:0] rd_ptr  = '0;
   logic [2:0] rd_addr = '0;
   logic [3:0] o_rd_data;
   logic [3:0] o_wr_ptr_gray;
   logic       o_full;
   logic       o_overflow;
   logic [7:0] o_drop_cnt;

   typedef struct packed {
      logic [2:0] addr;
      logic [3:0] tag;
   } sb_t;

   sb_t sb[$];
   int  tests = 0;
   int  fails = 0;

   encout_elc_in_event_queue_wr #(
      .AW(3), .TAG_W(4), .DROP_W(8), .SYNC_STAGES(2)
   ) dut (
      .w_elc_in_act_clk    (clk),
      .w_elc_in_act_resetn (rst_n),
      .i_elc_tag           (tag),
      .i_rd_ptr_gray       (rd_ptr),
      .i_rd_addr           (rd_addr),
      .o_rd_data           (o_rd_data),
      .o_wr_ptr_gray       (o_wr_ptr_gray),
      .o_full              (o_full),
      .o_overflow          (o_overflow),
      .o_drop_cnt          (o_drop_cnt)
   );

   // Gated clock: a rising edge only when events are being issued
   always begin
      #5;
      clk = clk_run;
      #5;
      clk = 1'b0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic edge_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_edge(input logic [3:0] t, input logic [2:0] a);
      tag = t;
      sb.push_back({a, t});
      edge_tick();
   endtask

   task automatic drain(input string name);
      sb_t e;
      clk_run = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         tests++;
         if (o_rd_data !== e.tag) begin
            fails++;
            $display("FAIL %s rd_data[%0d]: got %h expected %h", name, e.addr, o_rd_data, e.tag);
         end
      end
      clk_run = 1'b1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rd_ptr = '0; tag = '0; rd_addr = '0;
      clk_run = 1'b1;
      repeat (3) edge_tick();
      tests++; if (o_wr_ptr_gray !== 4'b0000) begin fails++; $display("FAIL reset gray: got %b expected 0000", o_wr_ptr_gray); end
      tests++; if (o_full !== 1'b0) begin fails++; $display("FAIL reset full: got %b expected 0", o_full); end
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset overflow: got %b expected 0", o_overflow); end
      tests++; if (o_drop_cnt !== 8'd0) begin fails++; $display("FAIL reset drop_cnt: got %0d expected 0", o_drop_cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_writes();
      logic [3:0] exp_gray [3] = '{4'b0001, 4'b0011, 4'b0010};
      for (int i = 0; i < 3; i++) begin
         wr_edge(4'(i + 1), 3'(i));
         tests++;
         if (o_wr_ptr_gray !== exp_gray[i]) begin
            fails++;
            $display("FAIL basic gray edge %0d: got %b expected %b", i + 1, o_wr_ptr_gray, exp_gray[i]);
         end
      end
      tests++; if (o_full !== 1'b0) begin fails++; $display("FAIL basic full: got %b expected 0", o_full); end
      drain("basic");
   endtask

   task automatic test_fill_drop();
      reset_pulse();
      rd_ptr = '0;
      for (int i = 0; i < 8; i++) wr_edge(4'(i + 4), 3'(i));
      tests++; if (o_wr_ptr_gray !== 4'b1100) begin fails++; $display("FAIL fill gray: got %b expected 1100", o_wr_ptr_gray); end
      tests++; if (o_full !== 1'b1) begin fails++; $display("FAIL fill full: got %b expected 1", o_full); end
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL fill overflow early: got %b expected 0", o_overflow); end
      tag = 4'hF;
      edge_tick();
      tests++; if (o_wr_ptr_gray !== 4'b1100) begin fails++; $display("FAIL drop gray held: got %b expected 1100", o_wr_ptr_gray); end
      tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL drop overflow: got %b expected 1", o_overflow); end
      tests++; if (o_drop_cnt !== 8'd1) begin fails++; $display("FAIL drop count: got %0d expected 1", o_drop_cnt); end
      drain("fill");
   endtask

   task automatic test_sync_wrap();
      rd_ptr = 4'b1100;
      tag = 4'hA;
      edge_tick();
      tests++; if (o_drop_cnt !== 8'd2) begin fails++; $display("FAIL sync edge1 drop_cnt: got %0d expected 2", o_drop_cnt); end
      tests++; if (o_full !== 1'b1) begin fails++; $display("FAIL sync edge1 full: got %b expected 1", o_full); end
      edge_tick();
      tests++; if (o_drop_cnt !== 8'd3) begin fails++; $display("FAIL sync edge2 drop_cnt: got %0d expected 3", o_drop_cnt); end
      tests++; if (o_full !== 1'b0) begin fails++; $display("FAIL sync edge2 full: got %b expected 0", o_full); end
      tests++; if (o_wr_ptr_gray !== 4'b1100) begin fails++; $display("FAIL sync edge2 gray: got %b expected 1100", o_wr_ptr_gray); end
      wr_edge(4'hA, 3'd0);
      tests++; if (o_wr_ptr_gray !== 4'b1101) begin fails++; $display("FAIL wrap gray: got %b expected 1101", o_wr_ptr_gray); end
      tests++; if (o_drop_cnt !== 8'd3) begin fails++; $display("FAIL wrap drop_cnt: got %0d expected 3", o_drop_cnt); end
      drain("wrap");
   endtask

   task automatic test_saturation();
      // Seven more writes bring the pointer a full lap past the read pointer
      for (int i = 1; i < 8; i++) wr_edge(4'(i + 8), 3'(i));
      tests++; if (o_wr_ptr_gray !== 4'b0000) begin fails++; $display("FAIL sat wrap gray: got %b expected 0000", o_wr_ptr_gray); end
      tests++; if (o_full !== 1'b1) begin fails++; $display("FAIL sat full: got %b expected 1", o_full); end
      drain("sat_fill");
      tag = 4'h5;
      repeat (100) edge_tick();
      tests++; if (o_drop_cnt !== 8'd103) begin fails++; $display("FAIL sat mid drop_cnt: got %0d expected 103", o_drop_cnt); end
      repeat (200) edge_tick();
      tests++; if (o_drop_cnt !== 8'd255) begin fails++; $display("FAIL sat drop_cnt: got %0d expected 255", o_drop_cnt); end
      tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL sat overflow: got %b expected 1", o_overflow); end
      tests++; if (o_wr_ptr_gray !== 4'b0000) begin fails++; $display("FAIL sat gray held: got %b expected 0000", o_wr_ptr_gray); end
   endtask

   task automatic test_async_reset();
      rd_ptr = 4'b0000;
      repeat (2) edge_tick();
      tests++; if (o_full !== 1'b0) begin fails++; $display("FAIL async pre full: got %b expected 0", o_full); end
      for (int i = 0; i < 5; i++) wr_edge(4'(i + 1), 3'(i));
      tests++; if (o_wr_ptr_gray !== 4'b0111) begin fails++; $display("FAIL async pre gray: got %b expected 0111", o_wr_ptr_gray); end
      tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL async pre overflow: got %b expected 1", o_overflow); end
      rst_n = 1'b0;
      #1;
      tests++; if (o_wr_ptr_gray !== 4'b0000) begin fails++; $display("FAIL async gray: got %b expected 0000", o_wr_ptr_gray); end
      tests++; if (o_full !== 1'b0) begin fails++; $display("FAIL async full: got %b expected 0", o_full); end
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL async overflow: got %b expected 0", o_overflow); end
      tests++; if (o_drop_cnt !== 8'd0) begin fails++; $display("FAIL async drop_cnt: got %0d expected 0", o_drop_cnt); end
      #1;
      rst_n = 1'b1;
      drain("async_pre");
      wr_edge(4'h6, 3'd0);
      tests++; if (o_wr_ptr_gray !== 4'b0001) begin fails++; $display("FAIL async post gray: got %b expected 0001", o_wr_ptr_gray); end
      drain("async_post");
   endtask

   initial begin
      test_reset();
      test_basic_writes();
      test_fill_drop();
      test_sync_wrap();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
